// File: rtl/spi_master_if.sv
// spi_master_if: bundles the request/response handshake and the SPI pins of spi_master.
//
// Signals
//   start  request a frame (sampled by the master only while idle)
//   cmd    command byte, captured by the master when start is accepted
//   busy   master is working on a frame (accept cycle through done cycle)
//   done   one-cycle pulse at frame end
//   left   last received left sample (signed)
//   right  last received right sample (signed)
//   SCLK   SPI clock, idle low
//   CS     chip select, active low
//   MOSI   master data out, MSB first
//   MISO   slave data in, asynchronous to the master clock
//
// Modports
//   master  the spi_master side
//   slave   the requester / SPI peripheral side (testbench, system logic)

interface spi_master_if;
    logic               start;
    logic        [7:0]  cmd;
    logic               busy;
    logic               done;
    logic signed [15:0] left;
    logic signed [15:0] right;
    logic               SCLK;
    logic               CS;
    logic               MOSI;
    logic               MISO;

    modport master (
        input  start,
        input  cmd,
        input  MISO,
        output busy,
        output done,
        output left,
        output right,
        output SCLK,
        output CS,
        output MOSI
    );

    modport slave (
        output start,
        output cmd,
        output MISO,
        input  busy,
        input  done,
        input  left,
        input  right,
        input  SCLK,
        input  CS,
        input  MOSI
    );
endinterface

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master that issues a command byte and, for the read command
// (8'h01), clocks in a 16-bit left sample followed by a 16-bit right sample.
//
// Frame layout
//   cmd == 8'h01 : 40 bits = 8 cmd bits, 16 left bits, 16 right bits
//   otherwise    :  8 bits = cmd only (left/right keep their previous values)
//
// Timing (cycle 0 = accept cycle, D = CLK_DIV, N = frame bits)
//   CS low from cycle 1; first SCLK low half starts at 1+CS_SETUP;
//   each bit is D cycles SCLK low then D cycles SCLK high;
//   last SCLK fall at 1+CS_SETUP+2*D*N; CS high and done at that plus CS_HOLD.
//
// Parameters
//   CLK_DIV   SCLK half-period in clk_48 cycles (>= 4)
//   CS_SETUP  cycles from CS falling to the first SCLK low half (>= 1)
//   CS_HOLD   cycles from the last SCLK fall to CS rising (>= 1)
//
// Ports
//   clk_48   system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      spi_master_if master modport (handshake, sample outputs, SPI pins)

module spi_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2
) (
    input logic          clk_48,
    input logic          reset_n,
    spi_master_if.master bus
);

    localparam int unsigned PhaseMax = 2 * CLK_DIV - 1;
    localparam int unsigned CntMax0  = (PhaseMax > CS_SETUP) ? PhaseMax : CS_SETUP;
    localparam int unsigned CntMax   = (CntMax0 > CS_HOLD) ? CntMax0 : CS_HOLD;
    localparam int unsigned CntW     = $clog2(CntMax + 1);

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t SclkRise  = cnt_t'(CLK_DIV - 1);
    localparam cnt_t SclkFall  = cnt_t'(PhaseMax);
    localparam cnt_t SetupLast = cnt_t'(CS_SETUP - 1);
    localparam cnt_t HoldLast  = cnt_t'(CS_HOLD - 1);

    localparam logic [7:0] CmdRead    = 8'h01;
    localparam logic [5:0] LastBitRd  = 6'd39;
    localparam logic [5:0] LastBitCmd = 6'd7;
    localparam logic [5:0] FirstRxBit = 6'd8;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StDone
    } state_e;

    state_e             state_q;
    cnt_t               cnt_q;
    logic [5:0]         bit_q;
    logic               long_q;
    logic [6:0]         cmd_sh_q;
    logic [31:0]        rx_q;
    logic               sclk_q;
    logic               cs_q;
    logic               mosi_q;
    logic               busy_q;
    logic               done_q;
    logic signed [15:0] left_q;
    logic signed [15:0] right_q;
    logic               miso_meta_q;
    logic               miso_sync_q;
    logic [5:0]         last_bit;

    // MISO is asynchronous to clk_48; nothing downstream sees it before these two flops.
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            miso_meta_q <= bus.MISO;
            miso_sync_q <= miso_meta_q;
        end
    end

    assign last_bit = long_q ? LastBitRd : LastBitCmd;

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            long_q   <= 1'b0;
            cmd_sh_q <= '0;
            rx_q     <= '0;
            sclk_q   <= 1'b0;
            cs_q     <= 1'b1;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            left_q   <= '0;
            right_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    sclk_q <= 1'b0;
                    cs_q   <= 1'b1;
                    mosi_q <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q  <= StSetup;
                        cnt_q    <= '0;
                        bit_q    <= '0;
                        long_q   <= (bus.cmd == CmdRead);
                        // cmd[7] goes straight onto MOSI; the rest waits in the shifter.
                        mosi_q   <= bus.cmd[7];
                        cmd_sh_q <= bus.cmd[6:0];
                        cs_q     <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end

                StSetup: begin
                    if (cnt_q == SetupLast) begin
                        state_q <= StShift;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + cnt_t'(1);
                    end
                end

                StShift: begin
                    cnt_q <= cnt_q + cnt_t'(1);
                    if (cnt_q == SclkRise) begin
                        sclk_q <= 1'b1;
                    end
                    if (cnt_q == SclkFall) begin
                        // Last cycle of the high half: sample MISO, drop SCLK and move
                        // MOSI to the next bit on the same edge, so MOSI only changes
                        // while SCLK is low.
                        sclk_q   <= 1'b0;
                        cnt_q    <= '0;
                        cmd_sh_q <= {cmd_sh_q[5:0], 1'b0};
                        mosi_q   <= cmd_sh_q[6];
                        if (long_q && (bit_q >= FirstRxBit)) begin
                            rx_q <= {rx_q[30:0], miso_sync_q};
                        end
                        if (bit_q == last_bit) begin
                            state_q <= StHold;
                            mosi_q  <= 1'b0;
                        end else begin
                            bit_q <= bit_q + 6'd1;
                        end
                    end
                end

                StHold: begin
                    if (cnt_q == HoldLast) begin
                        state_q <= StDone;
                        cnt_q   <= '0;
                        cs_q    <= 1'b1;
                        done_q  <= 1'b1;
                        // Both samples change on the same edge so readers never see a
                        // new left paired with an old right.
                        if (long_q) begin
                            left_q  <= rx_q[31:16];
                            right_q <= rx_q[15:0];
                        end
                    end else begin
                        cnt_q <= cnt_q + cnt_t'(1);
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.SCLK  = sclk_q;
    assign bus.CS    = cs_q;
    assign bus.MOSI  = mosi_q;
    assign bus.done  = done_q;
    assign bus.left  = left_q;
    assign bus.right = right_q;

    // busy must already be high in the accept cycle, before any flop has seen start;
    // reset_n keeps it low while the block is held in reset.
    assign bus.busy = busy_q | ((state_q == StIdle) & bus.start & reset_n);

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk_48 cycles; legal range >= 4.
REQ-002 Parameter CS_SETUP, default 2: cycles from CS falling to the start of the first SCLK low half.
REQ-003 Parameter CS_HOLD, default 2: cycles from the last SCLK falling edge to CS rising.
REQ-004 clk_48  in  1  system clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request a frame; sampled only in IDLE.
REQ-007 cmd  in  8  command byte, captured when start is accepted.
REQ-008 busy  out  1  high from the accept cycle through the done cycle.
REQ-009 done  out  1  one-cycle pulse at frame end.
REQ-010 left  out  16 signed  last received left sample.
REQ-011 right  out  16 signed  last received right sample.
REQ-012 SCLK  out  1  SPI clock; idle low.
REQ-013 CS  out  1  chip select, active low; idle high.
REQ-014 MOSI  out  1  master data out, MSB first.
REQ-015 MISO  in  1  slave data in; asynchronous to clk_48.

Function
REQ-016 The block SHALL implement SPI mode 0: MOSI changes only while SCLK is low, and the slave samples MOSI on SCLK rising.
REQ-017 All SPI outputs (SCLK, CS, MOSI) SHALL come directly from flops, so they are glitch-free.
REQ-018 MISO SHALL pass through a 2-flop synchronizer before any use.
REQ-019 FSM states and transitions:
  - IDLE -> SETUP when start=1; cmd is captured.
  - SETUP -> SHIFT after CS_SETUP cycles.
  - SHIFT -> HOLD after N bits.
  - HOLD -> DONE after CS_HOLD cycles.
  - DONE -> IDLE after 1 cycle.
REQ-020 Frame length SHALL be N=40 bits when captured cmd == 8'h01, else N=8.
  - 40-bit frame: 8 cmd bits, then 16 left bits, then 16 right bits.
  - 8-bit frame: cmd only.
REQ-021 Cycle numbering: cycle 0 is the accept cycle; CS SHALL be 0 from cycle 1.
REQ-022 Each bit SHALL take 2*CLK_DIV cycles: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-023 MOSI SHALL present cmd[7-k] for the whole of bit k (k = 0..7).
REQ-024 MOSI SHALL be 0 for bits 8..39.
REQ-025 The synchronized MISO SHALL be sampled in the last clk_48 cycle of each SCLK-high half, for bits 8..39 only.
REQ-026 Received bits SHALL shift MSB first: bits 8..23 form left[15:0], bits 24..39 form right[15:0].
REQ-027 Last SCLK falling edge SHALL occur at cycle 1+CS_SETUP+2*CLK_DIV*N.
REQ-028 CS SHALL return to 1 at cycle 1+CS_SETUP+2*CLK_DIV*N+CS_HOLD.
REQ-029 done SHALL pulse in the same cycle CS returns to 1.
REQ-030 left/right SHALL update atomically in the done cycle, and only for 40-bit frames.
REQ-031 For 8-bit frames, left/right SHALL hold their previous values.
REQ-032 start asserted while busy=1 SHALL be ignored; it is not queued.
REQ-033 With start held high continuously, the next frame SHALL be accepted the cycle after done, giving CS high for exactly 2 cycles between frames.
REQ-034 The cmd input SHALL be ignored after the accept cycle; changes mid-frame SHALL NOT affect MOSI.

Reset
REQ-035 While reset_n=0, the following SHALL hold immediately, with no clock required:
  - SCLK=0, CS=1, MOSI=0;
  - busy=0, done=0;
  - left=0, right=0;
  - FSM in IDLE; synchronizer and counters cleared.
REQ-036 Reset asserted mid-frame SHALL abort the frame: no done pulse, left/right=0.
REQ-037 The first frame after reset release SHALL behave exactly as from power-up.

Verification
REQ-038 Reset: hold reset_n=0 with random start/MISO -> SCLK=0, CS=1, MOSI=0, busy=0, done=0, left=right=0.
REQ-039 Read frame: defaults, cmd=8'h01, slave model drives 0x1234 then 0xABCD on SCLK falling.
  - MOSI bits are 0000_0001; exactly 40 SCLK pulses.
  - done at cycle 325; left=16'h1234, right=16'hABCD (-21555).
REQ-040 Non-read frame: cmd=8'h5A -> 8 SCLK pulses with MOSI 0101_1010, done at cycle 69, left/right unchanged.
REQ-041 Handshake:
  - start pulsed at cycle 100 of a frame -> ignored, single done.
  - start held high -> back-to-back frames, CS high exactly 2 cycles between them.
REQ-042 Reset mid-frame: assert reset_n=0 during bit 20 -> CS=1, SCLK=0, no done, left=right=0; next cmd=8'h01 frame returns correct data.
REQ-043 Edge data: slave returns left=16'h8000, right=16'h0001 -> left=-32768, right=1; repeat with CLK_DIV=4, 8 and 16, with done timing per REQ-027 to REQ-029.
